gpr_read_arb: RTL and testbench

GPR_READ_ARB -- requirements
Module: gpr_read_arb

---
 rtl/gpr_pkg.sv | 31 +++
 rtl/rr_arb3.sv | 26 ++
 rtl/gpr_read_arb.sv | 117 +++++++++++
 tb/tb_gpr_read_arb.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared types and default sizes for the GPR read arbiter and its round-robin picker.
package gpr_pkg;

  localparam int NUM_GPR   = 13;
  localparam int GPR_IDX_W = 4;
  localparam int GPR_DW    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REQ_A = 2'd0,
    REQ_B = 2'd1,
    REQ_D = 2'd2
  } req_id_t;

  // Requester that gets first look after id has been served; D is skipped when the debug port is off.
  function automatic req_id_t next_req(req_id_t id, logic dbg_en);
    req_id_t nxt;
    case (id)
      REQ_A:   nxt = REQ_B;
      REQ_B:   if (dbg_en) nxt = REQ_D; else nxt = REQ_A;
      default: nxt = REQ_A;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin picker: the first active request at or after ptr wins (one-hot grant).
module rr_arb3
  import gpr_pkg::*;
(
  input  logic [2:0] req,
  input  req_id_t    ptr,
  output logic [2:0] gnt
);

  always_comb begin
    logic       found;
    logic [1:0] pos;
    // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
    gnt   = '0;
    found = 1'b0;
    pos   = 2'd0;
    for (int k = 0; k < 3; k++) begin
      pos = 2'((int'(ptr) + k) % 3);
      if (!found && req[pos]) begin
        gnt[pos] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpr_read_arb.sv
// Three-requester read arbiter in front of GPR_MUX: grant, drive sel, capture and return data.
// Define GPR_ARB_DBG_EN to let the debug requester (D) join the round-robin.
module gpr_read_arb #(
  parameter int NUM_GPR = gpr_pkg::NUM_GPR,
  parameter int DW      = gpr_pkg::GPR_DW
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           a_req,
  input  logic                           b_req,
  input  logic                           d_req,
  input  logic [gpr_pkg::GPR_IDX_W-1:0]  a_idx,
  input  logic [gpr_pkg::GPR_IDX_W-1:0]  b_idx,
  input  logic [gpr_pkg::GPR_IDX_W-1:0]  d_idx,
  output logic                           a_gnt,
  output logic                           b_gnt,
  output logic                           d_gnt,
  output logic                           a_rvalid,
  output logic                           b_rvalid,
  output logic                           d_rvalid,
  output logic [DW-1:0]                  rdata,
  output logic                           err,
  output logic [gpr_pkg::GPR_IDX_W-1:0]  sel,
  input  logic [DW-1:0]                  mux_data
);

  import gpr_pkg::*;

`ifdef GPR_ARB_DBG_EN
  localparam logic DBG_EN = 1'b1;
`else
  localparam logic DBG_EN = 1'b0;
`endif

  localparam int IW = GPR_IDX_W;

  state_t          state_q, state_d;
  req_id_t         rr_ptr_q, win_q, pick_id;
  logic [IW-1:0]   idx_q, pick_idx;
  logic [DW-1:0]   rdata_q;
  logic [2:0]      req_vec, pick;
  logic            idx_legal;

  // With the debug port disabled d_req is masked here, so D can never win.
  assign req_vec   = {d_req & DBG_EN, b_req, a_req};
  assign idx_legal = int'(idx_q) < NUM_GPR;

  rr_arb3 u_rr_arb3 (
    .req (req_vec),
    .ptr (rr_ptr_q),
    .gnt (pick)
  );

  always_comb begin
    pick_id  = REQ_A;
    pick_idx = a_idx;
    if (pick[1]) begin
      pick_id  = REQ_B;
      pick_idx = b_idx;
    end else if (pick[2]) begin
      pick_id  = REQ_D;
      pick_idx = d_idx;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    d_gnt    = 1'b0;
    a_rvalid = 1'b0;
    b_rvalid = 1'b0;
    d_rvalid = 1'b0;
    err      = 1'b0;
    case (state_q)
      IDLE: if (|req_vec) state_d = CAPT;
      CAPT: begin
        state_d = RESP;
        a_gnt   = (win_q == REQ_A);
        b_gnt   = (win_q == REQ_B);
        d_gnt   = DBG_EN && (win_q == REQ_D);
      end
      RESP: begin
        state_d  = IDLE;
        a_rvalid = (win_q == REQ_A);
        b_rvalid = (win_q == REQ_B);
        d_rvalid = DBG_EN && (win_q == REQ_D);
        err      = !idx_legal;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= REQ_A;
      win_q    <= REQ_A;
      idx_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |req_vec) begin
        win_q <= pick_id;
        idx_q <= pick_idx;
      end
      // Out-of-range indices return zero rather than whatever the mux presents.
      if (state_q == CAPT) rdata_q <= idx_legal ? mux_data : '0;
      if (state_q == RESP) rr_ptr_q <= next_req(win_q, DBG_EN);
    end
  end

  assign sel   = idx_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_gpr_read_arb.sv
// Self-checking bench for gpr_read_arb: directed scenarios plus random traffic against a transaction model.
module tb_gpr_read_arb;

  localparam int NGPR = 13;
  localparam int DW   = 32;
`ifdef GPR_ARB_DBG_EN
  localparam bit TB_DBG = 1'b1;
`else
  localparam bit TB_DBG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, b_req, d_req;
  logic [3:0]    a_idx, b_idx, d_idx;
  logic          a_gnt, b_gnt, d_gnt;
  logic          a_rvalid, b_rvalid, d_rvalid;
  logic [DW-1:0] rdata;
  logic          err;
  logic [3:0]    sel;
  logic [DW-1:0] mux_data;

  gpr_read_arb #(.NUM_GPR(NGPR), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_req    (a_req),
    .b_req    (b_req),
    .d_req    (d_req),
    .a_idx    (a_idx),
    .b_idx    (b_idx),
    .d_idx    (d_idx),
    .a_gnt    (a_gnt),
    .b_gnt    (b_gnt),
    .d_gnt    (d_gnt),
    .a_rvalid (a_rvalid),
    .b_rvalid (b_rvalid),
    .d_rvalid (d_rvalid),
    .rdata    (rdata),
    .err      (err),
    .sel      (sel),
    .mux_data (mux_data)
  );

  always #5 clk = ~clk;

  // GPR_MUX stand-in: rA..rM hold 1..13; unused mux inputs return junk the arbiter must suppress.
  assign mux_data = (int'(sel) < NGPR) ? 32'(sel) + 32'd1 : 32'hDEAD_BEEF;

  int          total = 0;
  int          bad   = 0;
  bit          pend [3];
  logic [3:0]  ridx [3];
  int          phase, win, ptr;
  logic [3:0]  m_sel;
  logic [31:0] m_rdata;
  logic        m_err;
  int          served [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit [2:0] en, input int p);
    for (int k = 0; k < 3; k++) begin
      if (en[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  task automatic model_reset();
    phase   = 0;
    ptr     = 0;
    win     = 0;
    m_sel   = '0;
    m_rdata = '0;
    m_err   = 1'b0;
  endtask

  task automatic drive();
    a_req = pend[0]; a_idx = ridx[0];
    b_req = pend[1]; b_idx = ridx[1];
    d_req = pend[2]; d_idx = ridx[2];
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s_gnt", tag), {29'b0, d_gnt, b_gnt, a_gnt}, 32'd0);
    check($sformatf("%s_rvalid", tag), {29'b0, d_rvalid, b_rvalid, a_rvalid}, 32'd0);
    check($sformatf("%s_err", tag), {31'b0, err}, 32'd0);
    check($sformatf("%s_sel", tag), {28'b0, sel}, 32'd0);
    check($sformatf("%s_rdata", tag), rdata, 32'd0);
  endtask

  // One clock: check this cycle's outputs, let the requesters react, then advance the model across the edge.
  task automatic step(input string tag);
    logic [2:0] eg, er;
    int         w;
    @(negedge clk);
    eg = (phase == 1) ? 3'(1 << win) : 3'b000;
    er = (phase == 2) ? 3'(1 << win) : 3'b000;
    check($sformatf("%s_gnt", tag), {29'b0, d_gnt, b_gnt, a_gnt}, {29'b0, eg});
    check($sformatf("%s_rvalid", tag), {29'b0, d_rvalid, b_rvalid, a_rvalid}, {29'b0, er});
    check($sformatf("%s_err", tag), {31'b0, err}, {31'b0, (phase == 2) && m_err});
    check($sformatf("%s_sel", tag), {28'b0, sel}, {28'b0, m_sel});
    check($sformatf("%s_rdata", tag), rdata, m_rdata);
    if (a_rvalid) served.push_back(0);
    else if (b_rvalid) served.push_back(1);
    else if (d_rvalid) served.push_back(2);
    if (phase == 1) pend[win] = 1'b0;
    drive();
    case (phase)
      0: begin
        w = pick({TB_DBG & pend[2], pend[1], pend[0]}, ptr);
        if (w >= 0) begin
          win   = w;
          m_sel = ridx[w];
          phase = 1;
        end
      end
      1: begin
        m_err   = int'(m_sel) >= NGPR;
        m_rdata = m_err ? 32'd0 : 32'(m_sel) + 32'd1;
        phase   = 2;
      end
      default: begin
        ptr = (win + 1) % 3;
        if (!TB_DBG && ptr == 2) ptr = 0;
        phase = 0;
      end
    endcase
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b0;
      ridx[i] = '0;
    end
    drive();
    model_reset();
    #1;
    check_all_zero(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    apply_reset("reset");

    // Single legal read by A.
    pend[0] = 1'b1; ridx[0] = 4'd4;
    repeat (5) step("a_idx4");

    // All three held from a fresh pointer: service order follows the ring.
    apply_reset("reset2");
    pend[0] = 1'b1; ridx[0] = 4'd0;
    pend[1] = 1'b1; ridx[1] = 4'd1;
    pend[2] = 1'b1; ridx[2] = 4'd2;
    served.delete();
    repeat (11) step("all3");
    check("all3_count", 32'(served.size()), TB_DBG ? 32'd3 : 32'd2);
    check("all3_first", (served.size() > 0) ? 32'(served[0]) : 32'd99, 32'd0);
    check("all3_second", (served.size() > 1) ? 32'(served[1]) : 32'd99, 32'd1);
    if (TB_DBG) check("all3_third", (served.size() > 2) ? 32'(served[2]) : 32'd99, 32'd2);
    pend[2] = 1'b0;

    // Illegal index from B.
    pend[1] = 1'b1; ridx[1] = 4'd14;
    repeat (5) step("b_idx14");

    // Index sweep through A.
    for (int i = 0; i < 16; i++) begin
      pend[0] = 1'b1;
      ridx[0] = 4'(i);
      repeat (4) step($sformatf("sweep%0d", i));
    end

    // Reset during A's capture cycle.
    apply_reset("reset3");
    pend[0] = 1'b1; ridx[0] = 4'd7;
    step("abort_req");
    @(posedge clk);
    #1;
    check("abort_gnt_before", {31'b0, a_gnt}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort_now");
    pend[0] = 1'b0;
    drive();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    served.delete();
    repeat (4) step("abort_post");
    check("abort_no_rvalid", 32'(served.size()), 32'd0);
    pend[0] = 1'b1; ridx[0] = 4'd3;
    pend[1] = 1'b1; ridx[1] = 4'd5;
    repeat (8) step("abort_rr");
    check("abort_rr_first", (served.size() > 0) ? 32'(served[0]) : 32'd99, 32'd0);

    // Debug requester alongside A.
    apply_reset("reset4");
    pend[0] = 1'b1; ridx[0] = 4'd2;
    pend[2] = 1'b1; ridx[2] = 4'd6;
    served.delete();
    repeat (10) step("dbg");
    check("dbg_count", 32'(served.size()), TB_DBG ? 32'd2 : 32'd1);
    check("dbg_first", (served.size() > 0) ? 32'(served[0]) : 32'd99, 32'd0);
    pend[2] = 1'b0;
    repeat (4) step("dbg_drain");

    // Random traffic with requests arriving in every phase.
    apply_reset("reset5");
    repeat (600) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i]) begin
          ridx[i] = 4'($urandom_range(0, 15));
          if ($urandom_range(0, 3) == 0) pend[i] = 1'b1;
        end
      end
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
